// File: rtl/ps2_host_cmd.sv
// Host-to-keyboard command path: CPU writes to ports 060h/064h are queued as
// {is_cmd, data} entries and drained by the RISC-V supervisor through a 4-word window.
module ps2_host_cmd #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  r_addr,
  input  logic [31:0] r_din,
  output logic [31:0] r_dout,
  input  logic [3:0]  r_lane,
  input  logic        r_wr,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [11:0] port,
  input  logic [7:0]  din,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  output logic        ibf,
  output logic        overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  iowr_armed;

  logic        accept;
  logic        iowr;
  logic        port_hit;
  logic        nonempty;
  logic        full;
  logic        ctrl_wr;
  logic        do_flush;
  logic        do_clr;
  logic        do_pop;
  logic        push_req;
  logic        do_push;
  logic        drop;
  logic [5:0]  cnt6;
  logic [8:0]  entry;
  logic [31:0] peek_word;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{r_lane, r_addr[9:2], r_din[31:2]};

  assign accept   = r_valid & ~r_ready;
  assign iowr     = cpu_iowrin ^ cpu_iowrout;
  assign port_hit = (port == 12'h060) || (port == 12'h064);
  assign nonempty = (count != '0);
  assign full     = (count == FULL_CNT);
  assign ctrl_wr  = accept & r_wr & (r_addr[1:0] == 2'd2);
  assign do_flush = ctrl_wr & r_din[0];
  assign do_clr   = ctrl_wr & r_din[1];
  assign do_pop   = accept & ~r_wr & (r_addr[1:0] == 2'd1) & nonempty;

  // A toggle left pending across reset is acknowledged but never queued.
  assign push_req = iowr & iowr_armed & port_hit & ~do_flush;
  assign do_push  = push_req & (~full | do_pop);
  assign drop     = push_req & full & ~do_pop;

  assign cnt6      = 6'(count);
  assign entry     = mem[rp];
  assign peek_word = {overflow, 14'b0, cnt6, nonempty, 1'b0, entry};

  always_comb begin
    count_next = count;
    if (do_flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    if (!r_wr) begin
      case (r_addr[1:0])
        2'd0, 2'd1: rd_word = peek_word;
        2'd2:       rd_word = {overflow, 25'b0, cnt6};
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= {port[2], din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp          <= '0;
      wp          <= '0;
      count       <= '0;
      r_dout      <= '0;
      r_ready     <= 1'b0;
      cpu_iowrout <= 1'b0;
      iowr_armed  <= 1'b0;
      ibf         <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      cpu_iowrout <= cpu_iowrin;
      iowr_armed  <= 1'b1;
      r_ready     <= accept;
      if (accept) r_dout <= rd_word;
      if (do_push) wp <= wp + 1'b1;
      if (do_flush) rp <= wp;
      else if (do_pop) rp <= rp + 1'b1;
      count <= count_next;
      ibf   <= (count_next != '0);
      if (drop) overflow <= 1'b1;
      else if (do_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Bench for ps2_host_cmd: fixed vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_ps2_host_cmd;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  r_addr = '0;
  logic [31:0] r_din = '0;
  logic [31:0] r_dout;
  logic [3:0]  r_lane = '0;
  logic        r_wr = 1'b0;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [11:0] port = '0;
  logic [7:0]  din = '0;
  logic        cpu_iowrin = 1'b0;
  logic        cpu_iowrout;
  logic        ibf;
  logic        overflow;

  always #5 clk = ~clk;

  ps2_host_cmd #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .r_addr(r_addr), .r_din(r_din), .r_dout(r_dout), .r_lane(r_lane),
    .r_wr(r_wr), .r_valid(r_valid), .r_ready(r_ready),
    .port(port), .din(din),
    .cpu_iowrin(cpu_iowrin), .cpu_iowrout(cpu_iowrout),
    .ibf(ibf), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [8:0] mq[$];
  bit m_ovf   = 1'b0;
  bit m_ready = 1'b0;
  bit m_armed = 1'b0;

  typedef struct {
    logic        rv;
    logic        rwr;
    logic [1:0]  ra;
    logic [31:0] rd;
    logic        cw;
    logic [11:0] prt;
    logic [7:0]  dat;
    logic        e_ready;
    logic [31:0] e_dout;
    logic [31:0] e_mask;
    logic        e_ibf;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rv, input logic rwr, input logic [1:0] ra,
                              input logic [31:0] rd, input logic cw, input logic [11:0] prt,
                              input logic [7:0] dat, input logic e_ready, input logic [31:0] e_dout,
                              input logic [31:0] e_mask, input logic e_ibf, input logic e_ovf);
    vec_t v;
    v.rv = rv; v.rwr = rwr; v.ra = ra; v.rd = rd; v.cw = cw; v.prt = prt; v.dat = dat;
    v.e_ready = e_ready; v.e_dout = e_dout; v.e_mask = e_mask; v.e_ibf = e_ibf; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] msk);
    n_cmp++;
    if ((act & msk) !== (exp & msk)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, msk, $time);
    end
  endtask

  // One clock: drive at negedge, advance the model, check just after posedge.
  task automatic step(input logic rv, input logic rwr, input logic [1:0] ra, input logic [31:0] rd,
                      input logic cw, input logic [11:0] prt, input logic [7:0] dt);
    bit acc, flush, clr, drop, hit;
    int sz;
    logic [31:0] pk, exp_d, msk;
    @(negedge clk);
    r_valid = rv; r_wr = rwr; r_addr = {8'($urandom), ra}; r_din = rd;
    r_lane = 4'($urandom); port = prt; din = dt;
    if (cw) cpu_iowrin = ~cpu_iowrin;
    acc = rv && !m_ready;
    sz  = mq.size();
    pk  = {m_ovf, 14'b0, 6'(sz), (sz != 0), 1'b0, 9'h0};
    if (sz != 0) pk[8:0] = mq[0];
    msk = 32'hFFFF_FFFF;
    case (ra)
      2'd0, 2'd1: begin exp_d = pk; if (sz == 0) msk = 32'hFFFF_FE00; end
      2'd2:       exp_d = {m_ovf, 25'b0, 6'(sz)};
      default:    exp_d = 32'h0;
    endcase
    hit   = cw && m_armed && (prt == 12'h060 || prt == 12'h064);
    flush = acc && rwr && ra == 2'd2 && rd[0];
    clr   = acc && rwr && ra == 2'd2 && rd[1];
    drop  = 1'b0;
    if (acc && !rwr && ra == 2'd1 && sz != 0) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (hit) begin
      if (mq.size() < DEPTH) mq.push_back({prt[2], dt});
      else drop = 1'b1;
    end
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_ready = acc;
    m_armed = 1'b1;
    @(posedge clk);
    #1;
    chk("r_ready", 32'(r_ready), 32'(acc), 32'h1);
    if (acc && !rwr) chk("r_dout", r_dout, exp_d, msk);
    chk("cpu_iowrout", 32'(cpu_iowrout), 32'(cpu_iowrin), 32'h1);
    chk("ibf", 32'(ibf), 32'(mq.size() != 0), 32'h1);
    chk("overflow", 32'(overflow), 32'(m_ovf), 32'h1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic cpu_wr(input logic [11:0] prt, input logic [7:0] dt);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, prt, dt);
  endtask

  task automatic rd_req(input logic [1:0] ra);
    step(1'b1, 1'b0, ra, 32'h0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic wr_req(input logic [1:0] ra, input logic [31:0] rd);
    step(1'b1, 1'b1, ra, rd, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic do_reset(input logic pend);
    @(negedge clk);
    if (pend) cpu_iowrin = ~cpu_iowrin;
    reset_n = 1'b0;
    r_valid = 1'b0;
    #1;
    chk("rst_r_dout", r_dout, 32'h0, '1);
    chk("rst_r_ready", 32'(r_ready), 32'h0, '1);
    chk("rst_cpu_iowrout", 32'(cpu_iowrout), 32'h0, '1);
    chk("rst_ibf", 32'(ibf), 32'h0, '1);
    chk("rst_overflow", 32'(overflow), 32'h0, '1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_ready = 1'b0; m_armed = 1'b0;
    // first cycle out of reset: any stale toggle (port left at 060h) must not queue
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 12'h060, 8'hEE);
  endtask

  initial begin
    // rv rwr ra rd cw prt dat | ready dout mask ibf ovf
    tbl.push_back(mk(0,0,2'd0,32'h0,1,12'h060,8'hED, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(1,0,2'd0,32'h0,0,12'h000,8'h00, 1,32'h0000_0CED,32'hFFFF_FFFF,1,0));
    tbl.push_back(mk(1,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(1,0,2'd1,32'h0,0,12'h000,8'h00, 1,32'h0000_0CED,32'hFFFF_FFFF,0,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,1,12'h064,8'hAA, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,1,12'h060,8'h55, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(1,0,2'd2,32'h0,0,12'h000,8'h00, 1,32'h0000_0002,32'hFFFF_FFFF,1,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(1,0,2'd1,32'h0,0,12'h000,8'h00, 1,32'h0000_15AA,32'hFFFF_FFFF,1,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        1,0));
    tbl.push_back(mk(1,0,2'd1,32'h0,0,12'h000,8'h00, 1,32'h0000_0C55,32'hFFFF_FFFF,0,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        0,0));
    tbl.push_back(mk(1,0,2'd1,32'h0,0,12'h000,8'h00, 1,32'h0,        32'hFFFF_FE00,0,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        0,0));
    tbl.push_back(mk(1,0,2'd3,32'h0,0,12'h000,8'h00, 1,32'h0,        32'hFFFF_FFFF,0,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        0,0));
    tbl.push_back(mk(1,1,2'd0,32'hFFFF_FFFF,0,12'h000,8'h00, 1,32'h0,32'h0,        0,0));
    tbl.push_back(mk(0,0,2'd0,32'h0,0,12'h000,8'h00, 0,32'h0,        32'h0,        0,0));

    do_reset(1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].rwr, tbl[i].ra, tbl[i].rd, tbl[i].cw, tbl[i].prt, tbl[i].dat);
      chk($sformatf("tbl%0d_ready", i), 32'(r_ready), 32'(tbl[i].e_ready), 32'h1);
      if (tbl[i].e_mask != 32'h0) chk($sformatf("tbl%0d_dout", i), r_dout, tbl[i].e_dout, tbl[i].e_mask);
      chk($sformatf("tbl%0d_ibf", i), 32'(ibf), 32'(tbl[i].e_ibf), 32'h1);
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf), 32'h1);
    end

    // overflow: nine writes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) cpu_wr(12'h060, 8'(i));
    rd_req(2'd2);
    chk("t3_status", r_dout, 32'h8000_0008, '1);
    idle();
    for (int i = 1; i <= 8; i++) begin
      rd_req(2'd1);
      chk($sformatf("t3_pop%0d", i), r_dout, 32'(i), 32'h0000_01FF);
      idle();
    end
    wr_req(2'd2, 32'h2);
    chk("t3_ovf_clr", 32'(overflow), 32'h0, '1);
    idle();

    // push on full with a simultaneous POP
    for (int i = 0; i < 8; i++) cpu_wr(12'h060, 8'h10 + 8'(i));
    step(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 12'h060, 8'h77);
    chk("t4_pop_oldest", r_dout, 32'h0000_0010, 32'h0000_01FF);
    idle();
    rd_req(2'd2);
    chk("t4_status", r_dout, 32'h0000_0008, '1);
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_req(2'd1);
      idle();
    end
    chk("t4_last_out", r_dout, 32'h0000_0077, 32'h0000_01FF);

    // flush wins over a same-cycle push; overflow-clear still applies
    cpu_wr(12'h060, 8'h21);
    cpu_wr(12'h064, 8'h22);
    step(1'b1, 1'b1, 2'd2, 32'h1, 1'b1, 12'h064, 8'h99);
    idle();
    chk("flush_ibf", 32'(ibf), 32'h0, '1);
    for (int i = 0; i < 9; i++) cpu_wr(12'h064, 8'h30 + 8'(i));
    step(1'b1, 1'b1, 2'd2, 32'h3, 1'b1, 12'h060, 8'h98);
    chk("flush_clr_ovf", 32'(overflow), 32'h0, '1);
    idle();

    // writes to unrelated ports are acknowledged only
    cpu_wr(12'h061, 8'h12);
    chk("t5_ack061", 32'(cpu_iowrout), 32'(cpu_iowrin), '1);
    cpu_wr(12'h070, 8'h34);
    chk("t5_ack070", 32'(cpu_iowrout), 32'(cpu_iowrin), '1);
    chk("t5_ibf", 32'(ibf), 32'h0, '1);
    rd_req(2'd2);
    chk("t5_status", r_dout, 32'h0, '1);
    idle();

    // reset mid-stream with a CPU write pending
    cpu_wr(12'h060, 8'h41);
    cpu_wr(12'h064, 8'h42);
    cpu_wr(12'h060, 8'h43);
    if (cpu_iowrin) cpu_wr(12'h070, 8'h00);
    do_reset(1'b1);
    chk("t6_ibf_after_rst", 32'(ibf), 32'h0, '1);
    cpu_wr(12'h060, 8'h5A);
    rd_req(2'd0);
    chk("t6_peek", r_dout, 32'h0000_0C5A, '1);
    idle();
    rd_req(2'd1);
    idle();
    rd_req(2'd1);
    chk("t6_empty", r_dout, 32'h0, 32'hFFFF_FE00);
    idle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic rv, rwr, cw;
      logic [1:0] ra;
      logic [31:0] rd;
      logic [11:0] prt;
      rv  = ($urandom_range(0, 2) == 0);
      rwr = ($urandom_range(0, 4) == 0);
      ra  = 2'($urandom);
      rd  = {30'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0)};
      cw  = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0, 1, 2: prt = 12'h060;
        3:       prt = 12'h064;
        4:       prt = 12'h061;
        default: prt = 12'($urandom);
      endcase
      step(rv, rwr, ra, rd, cw, prt, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
